// File: rtl/param_serial_div.sv
// rtl/param_serial_div.sv - multi-cycle restoring divider with optional signed mode, abort and divide-by-zero flag
module param_serial_div #(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 busy_o,
    output logic                 dbz_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DBZ  = 2'd1;
    localparam logic [1:0] S_ON   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] quo_q;     // dividend magnitude, shifted out as quotient bits shift in
    logic [WIDTH-1:0] rem_q;     // partial remainder
    logic [WIDTH-1:0] dvs_q;     // divisor magnitude
    logic             sign_a;
    logic             sign_b;
    logic             mode_q;

    logic             mode_in;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic             step_neg;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    // Operand magnitudes, one restoring step, and final sign correction
    always_comb begin
        mode_in  = SIGNED_EN && signed_div_i;
        a_mag    = (mode_in && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        b_mag    = (mode_in && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
        rem_sh   = {rem_q, quo_q[WIDTH-1]};
        diff     = rem_sh - {1'b0, dvs_q};
        step_neg = diff[WIDTH];
        quo_fix  = (mode_q && (sign_a ^ sign_b)) ? -quo_q : quo_q;
        rem_fix  = (mode_q && sign_a) ? -rem_q : rem_q;
    end

    // Control FSM, datapath and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            mode_q   <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
            busy_o   <= 1'b0;
            dbz_o    <= 1'b0;
        end else if (annul_i) begin
            state    <= S_IDLE;
            cnt      <= '0;
            result_o <= '0;
            ready_o  <= 1'b0;
            busy_o   <= 1'b0;
            dbz_o    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        quo_q  <= a_mag;
                        rem_q  <= '0;
                        dvs_q  <= b_mag;
                        sign_a <= opdata1_i[WIDTH-1];
                        sign_b <= opdata2_i[WIDTH-1];
                        mode_q <= mode_in;
                        cnt    <= '0;
                        busy_o <= 1'b1;
                        state  <= (opdata2_i == '0) ? S_DBZ : S_ON;
                    end
                end
                S_DBZ: begin
                    result_o <= '0;
                    dbz_o    <= 1'b1;
                    ready_o  <= 1'b1;
                    busy_o   <= 1'b0;
                    state    <= S_DONE;
                end
                S_ON: begin
                    if (cnt == CNT_LAST) begin
                        result_o <= {rem_fix, quo_fix};
                        dbz_o    <= 1'b0;
                        ready_o  <= 1'b1;
                        busy_o   <= 1'b0;
                        state    <= S_DONE;
                    end else begin
                        rem_q <= step_neg ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
                        quo_q <= {quo_q[WIDTH-2:0], ~step_neg};
                        cnt   <= cnt + 1'b1;
                    end
                end
                default: begin
                    // DONE: hold until the requester drops start_i
                    if (!start_i) begin
                        result_o <= '0;
                        ready_o  <= 1'b0;
                        dbz_o    <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_param_serial_div.sv
// tb/tb_param_serial_div.sv - directed self-checking bench for param_serial_div
module tb_param_serial_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        sg32, st32, an32;
    logic [31:0] a32, b32;
    logic [63:0] res32;
    logic        rdy32, busy32, dbz32;
    logic        sg8, st8, an8;
    logic [7:0]  a8, b8;
    logic [15:0] res8;
    logic        rdy8, busy8, dbz8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    param_serial_div #(.WIDTH(32), .SIGNED_EN(1'b1)) dut32 (
        .clk(clk), .rst(rst), .signed_div_i(sg32), .opdata1_i(a32), .opdata2_i(b32),
        .start_i(st32), .annul_i(an32), .result_o(res32), .ready_o(rdy32),
        .busy_o(busy32), .dbz_o(dbz32)
    );

    param_serial_div #(.WIDTH(8), .SIGNED_EN(1'b1)) dut8 (
        .clk(clk), .rst(rst), .signed_div_i(sg8), .opdata1_i(a8), .opdata2_i(b8),
        .start_i(st8), .annul_i(an8), .result_o(res8), .ready_o(rdy8),
        .busy_o(busy8), .dbz_o(dbz8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] cur_res(input bit w8);
        return w8 ? {48'd0, res8} : res32;
    endfunction

    function automatic logic cur_rdy(input bit w8);
        return w8 ? rdy8 : rdy32;
    endfunction

    // Full transaction: start, count edges to ready, check result, hold, release
    task automatic op(input string tag, input bit w8, input bit sg,
                      input logic [31:0] a, input logic [31:0] b,
                      input int exp_n, input logic [63:0] exp_res, input bit exp_dbz);
        int n;
        logic [63:0] held;
        if (w8) begin sg8 = sg; a8 = a[7:0]; b8 = b[7:0]; st8 = 1'b1; end
        else    begin sg32 = sg; a32 = a; b32 = b; st32 = 1'b1; end
        n = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            n = i;
            if (i == 1) chk({tag, "_busy"}, w8 ? busy8 : busy32, 1'b1);
            if (i == 3) begin
                if (w8) begin a8 = ~a8; b8 = 8'd1; end
                else    begin a32 = ~a32; b32 = 32'd1; end
            end
            if (cur_rdy(w8)) break;
        end
        chk({tag, "_lat"}, n, exp_n);
        chk({tag, "_res"}, cur_res(w8), exp_res);
        chk({tag, "_dbz"}, w8 ? dbz8 : dbz32, exp_dbz);
        held = cur_res(w8);
        @(posedge clk); #1;
        chk({tag, "_hold"}, {cur_rdy(w8), cur_res(w8)}, {1'b1, held});
        if (w8) st8 = 1'b0; else st32 = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_rel"}, {cur_rdy(w8), (w8 ? dbz8 : dbz32), cur_res(w8)}, 66'd0);
    endtask

    initial begin
        int seen;
        rst = 1'b0;
        sg32 = 0; st32 = 0; an32 = 0; a32 = 0; b32 = 0;
        sg8 = 0; st8 = 0; an8 = 0; a8 = 0; b8 = 0;
        #1;
        chk("reset_out32", {rdy32, busy32, dbz32, res32}, 67'd0);
        chk("reset_out8", {rdy8, busy8, dbz8, res8}, 19'd0);
        #12 rst = 1'b1;

        op("u100_7", 0, 0, 32'd100, 32'd7, 34, {32'h2, 32'hE}, 0);
        op("s_m7_2", 0, 1, 32'hFFFFFFF9, 32'd2, 34, {32'hFFFFFFFF, 32'hFFFFFFFD}, 0);
        op("s_7_m2", 0, 1, 32'd7, 32'hFFFFFFFE, 34, {32'h1, 32'hFFFFFFFD}, 0);
        op("s_min_m1", 0, 1, 32'h80000000, 32'hFFFFFFFF, 34, {32'h0, 32'h80000000}, 0);
        op("u_big_2", 0, 0, 32'hFFFFFFF9, 32'd2, 34, {32'h1, 32'h7FFFFFFC}, 0);
        op("dbz55", 0, 0, 32'd55, 32'd0, 2, 64'd0, 1);

        // abort mid-operation
        a32 = 32'd1000; b32 = 32'd3; sg32 = 0; st32 = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        an32 = 1'b1; st32 = 1'b0;
        @(posedge clk); #1;
        chk("annul_idle", {rdy32, busy32, dbz32, res32}, 67'd0);
        an32 = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (rdy32) seen = 1;
        end
        chk("annul_no_rdy", seen, 0);
        op("u9_3", 0, 0, 32'd9, 32'd3, 34, {32'h0, 32'h3}, 0);

        // start and annul together: annul wins
        a32 = 32'd9; b32 = 32'd3; st32 = 1'b1; an32 = 1'b1;
        @(posedge clk); #1;
        chk("both_busy", busy32, 1'b0);
        st32 = 1'b0; an32 = 1'b0;
        @(posedge clk); #1;
        chk("both_rdy", rdy32, 1'b0);

        op("w8_u200_3", 1, 0, 32'd200, 32'd3, 10, {48'd0, 8'd2, 8'd66}, 0);
        op("w8_s80_ff", 1, 1, 32'h80, 32'hFF, 10, {48'd0, 8'h00, 8'h80}, 0);

        // asynchronous reset mid-operation
        a32 = 32'd1000; b32 = 32'd3; sg32 = 0; st32 = 1'b1;
        repeat (5) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("arst_out", {rdy32, busy32, dbz32, res32}, 67'd0);
        st32 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (rdy32 || busy32) seen = 1;
        end
        chk("arst_discard", seen, 0);
        op("u15_4", 0, 0, 32'd15, 32'd4, 34, {32'h3, 32'h3}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
